// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register offsets, response codes and FSM states for irq_ctrl
package irq_ctrl_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;  // 0x00
  localparam logic [1:0] REG_ENABLE  = 2'd1;  // 0x04
  localparam logic [1:0] REG_PENDING = 2'd2;  // 0x08
  localparam logic [1:0] REG_MODE    = 2'd3;  // 0x0C

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Address hits the 16-byte register window and is word aligned
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[31:4] == 28'd0) && (addr[1:0] == 2'b00);
  endfunction

  // Expand the four byte strobes into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchronizer with rising-edge detect for one irq line
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Two-stage synchronizer followed by a history flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= src;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller with AXI4-Lite register access
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_src,
  output logic              irq_out,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  // Bits at or above N_SRC are held at zero in every register
  localparam logic [31:0] SRC_MASK = (N_SRC >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << N_SRC) - 32'd1);

  logic [N_SRC-1:0] sync_level;
  logic [N_SRC-1:0] sync_rise;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .src   (irq_src[i]),
      .level (sync_level[i]),
      .rise  (sync_rise[i])
    );
  end

  logic [31:0] status_q;
  logic [31:0] enable_q;
  logic [31:0] mode_q;

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  logic              wr_fire;
  logic              wr_ok;
  logic [1:0]        wr_idx;
  logic [31:0]       wr_mask;
  logic [31:0]       set_vec;
  logic [31:0]       w1c_vec;
  logic              rd_ok;
  logic [31:0]       rd_val;

  // Decode the held write and form the per-bit set / clear vectors
  always_comb begin
    wr_fire = (wr_state == WR_IDLE) && aw_held && w_held;
    wr_ok   = addr_ok(32'(awaddr_q));
    wr_idx  = awaddr_q[3:2];
    wr_mask = strb_mask(wstrb_q);
    set_vec = '0;
    set_vec[N_SRC-1:0] = (mode_q[N_SRC-1:0] & sync_rise) |
                         (~mode_q[N_SRC-1:0] & sync_level);
    w1c_vec = '0;
    if (wr_fire && wr_ok && (wr_idx == REG_STATUS)) begin
      w1c_vec = wdata_q & wr_mask;
    end
  end

  // STATUS: W1C clear, then source set on top so a same-cycle set wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
    end else begin
      status_q <= ((status_q & ~w1c_vec) | set_vec) & SRC_MASK;
    end
  end

  // ENABLE and MODE: byte-lane gated read/write registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q <= '0;
      mode_q   <= '0;
    end else if (wr_fire && wr_ok) begin
      if (wr_idx == REG_ENABLE) begin
        enable_q <= ((enable_q & ~wr_mask) | (wdata_q & wr_mask)) & SRC_MASK;
      end
      if (wr_idx == REG_MODE) begin
        mode_q <= ((mode_q & ~wr_mask) | (wdata_q & wr_mask)) & SRC_MASK;
      end
    end
  end

  // Combined interrupt output, registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_out <= 1'b0;
    end else begin
      irq_out <= |(status_q & enable_q);
    end
  end

  // Write FSM: collect AW and W independently, update, then hold the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state      <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_held && w_held) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            wr_state      <= WR_RESP;
          end else begin
            if (s_axi_awvalid && s_axi_awready) begin
              awaddr_q      <= s_axi_awaddr;
              aw_held       <= 1'b1;
              s_axi_awready <= 1'b0;
            end else begin
              s_axi_awready <= !aw_held;
            end
            if (s_axi_wvalid && s_axi_wready) begin
              wdata_q      <= s_axi_wdata;
              wstrb_q      <= s_axi_wstrb;
              w_held       <= 1'b1;
              s_axi_wready <= 1'b0;
            end else begin
              s_axi_wready <= !w_held;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wr_state      <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read data mux; sees register values before any same-cycle write
  always_comb begin
    rd_ok  = addr_ok(32'(s_axi_araddr));
    rd_val = '0;
    case (s_axi_araddr[3:2])
      REG_STATUS:  rd_val = status_q;
      REG_ENABLE:  rd_val = enable_q;
      REG_PENDING: rd_val = status_q & enable_q;
      REG_MODE:    rd_val = mode_q;
      default:     rd_val = '0;
    endcase
    if (!rd_ok) begin
      rd_val = '0;
    end
  end

  // Read FSM: capture data on the AR handshake and hold it until rready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state      <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rdata   <= rd_val;
            s_axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            rd_state      <= RD_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state      <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq_src = '0;
  logic        irq_out;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  irq_ctrl #(.N_SRC(4), .ADDR_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_src       (irq_src),
    .irq_out       (irq_out),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t    rq[$];
  logic [1:0] wq[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er,
                           input int w_lead, input int b_delay);
    logic aw_pend, w_pend, aw_hs, w_hs, got;
    wq.push_back(er);
    awaddr = a; wdata = d; wstrb = s;
    wvalid = 1'b1;
    awvalid = (w_lead == 0);
    aw_pend = 1'b1; w_pend = 1'b1;
    for (int c = 0; c < 60 && (aw_pend || w_pend); c++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs) begin wvalid = 1'b0; w_pend = 1'b0; end
      if (aw_pend && !awvalid && (c + 1 >= w_lead)) awvalid = 1'b1;
    end
    if (aw_pend || w_pend) begin
      chk({tag, "_addr_data_timeout"}, 32'd0, 32'd1);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bvalid) begin got = 1'b1; break; end
    end
    if (!got) begin
      void'(wq.pop_front());
      chk({tag, "_bvalid_timeout"}, 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < b_delay; i++) begin
        chk({tag, "_bvalid_held"}, 32'(bvalid), 32'd1);
        chk({tag, "_no_second_aw"}, 32'(awready), 32'd0);
        chk({tag, "_no_second_w"}, 32'(wready), 32'd0);
        @(negedge clk);
      end
      bready = 1'b1;
      chk({tag, "_bresp"}, 32'(bresp), 32'(wq.pop_front()));
      @(posedge clk); #1;
      bready = 1'b0;
      chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
    end
  endtask

  task automatic axi_read(input string tag, input logic [7:0] a,
                          input logic [31:0] ed, input logic [1:0] er);
    rd_exp_t e;
    logic    hs, got;
    rq.push_back('{data: ed, resp: er});
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (arready) begin hs = 1'b1; @(posedge clk); #1; break; end
    end
    arvalid = 1'b0;
    got = 1'b0;
    if (hs) begin
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (rvalid) begin got = 1'b1; break; end
      end
    end
    e = rq.pop_front();
    if (!got) begin
      chk({tag, "_read_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
      chk({tag, "_rdata"}, rdata, e.data);
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_irq_out", 32'(irq_out), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst_aw", 32'(awready), 32'd1);
    chk("ready_after_rst_w", 32'(wready), 32'd1);
    chk("ready_after_rst_ar", 32'(arready), 32'd1);

    // Edge mode on source 0
    axi_write("en1", 8'h04, 32'h1, 4'hF, 2'b00, 0, 0);
    axi_write("mode1", 8'h0C, 32'h1, 4'hF, 2'b00, 0, 0);
    axi_read("rd_en1", 8'h04, 32'h1, 2'b00);
    axi_read("rd_mode1", 8'h0C, 32'h1, 2'b00);
    @(posedge clk); #1;
    irq_src = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("irq_latency_low", 32'(irq_out), 32'd0);
      @(posedge clk); #1;
      if (k == 2) irq_src = 4'b0000;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("irq_held_high", 32'(irq_out), 32'd1);
    end
    axi_read("rd_status_edge", 8'h00, 32'h1, 2'b00);
    axi_read("rd_pending_edge", 8'h08, 32'h1, 2'b00);

    // W1C without lane 0 strobe leaves bit 0 alone, then a full W1C clears it
    axi_write("w1c_nostrb", 8'h00, 32'h1, 4'b1110, 2'b00, 0, 0);
    axi_read("rd_status_nostrb", 8'h00, 32'h1, 2'b00);
    axi_write("w1c_bit0", 8'h00, 32'h1, 4'hF, 2'b00, 0, 0);
    chk("irq_after_w1c", 32'(irq_out), 32'd0);
    axi_read("rd_status_clr", 8'h00, 32'h0, 2'b00);

    // Level mode on source 2: W1C while high does not stick
    axi_write("mode0", 8'h0C, 32'h0, 4'hF, 2'b00, 0, 0);
    irq_src[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    axi_write("w1c_lvl_hi", 8'h00, 32'h4, 4'hF, 2'b00, 0, 0);
    axi_read("rd_status_lvl_hi", 8'h00, 32'h4, 2'b00);
    axi_read("rd_pending_lvl", 8'h08, 32'h0, 2'b00);
    chk("irq_lvl_masked", 32'(irq_out), 32'd0);
    irq_src[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    axi_write("w1c_lvl_lo", 8'h00, 32'h4, 4'hF, 2'b00, 0, 0);
    axi_read("rd_status_lvl_lo", 8'h00, 32'h0, 2'b00);

    // Unmapped / misaligned / read-only accesses
    axi_read("rd_unmapped", 8'h10, 32'h0, 2'b10);
    axi_read("rd_misaligned", 8'h05, 32'h0, 2'b10);
    axi_write("wr_unmapped", 8'h10, 32'hF, 4'hF, 2'b10, 0, 0);
    axi_write("wr_pending", 8'h08, 32'hF, 4'hF, 2'b00, 0, 0);
    axi_read("rd_en_after_bad", 8'h04, 32'h1, 2'b00);
    axi_read("rd_mode_after_bad", 8'h0C, 32'h0, 2'b00);
    axi_read("rd_status_after_bad", 8'h00, 32'h0, 2'b00);

    // W leads AW by 3 clk, bready withheld 5 clk
    axi_write("wlead", 8'h04, 32'h3, 4'hF, 2'b00, 3, 5);
    axi_read("rd_en_wlead", 8'h04, 32'h3, 2'b00);

    // Byte strobes and bits above N_SRC
    axi_write("en_upper_lanes", 8'h04, 32'hFFFF_FFFF, 4'b1110, 2'b00, 0, 0);
    axi_read("rd_en_upper", 8'h04, 32'h3, 2'b00);
    axi_write("en_lane0", 8'h04, 32'hFFFF_FFFF, 4'b0001, 2'b00, 0, 0);
    axi_read("rd_en_masked", 8'h04, 32'hF, 2'b00);

    // Reset while a read response is pending
    araddr = 8'h04; arvalid = 1'b1; rready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (arready) break;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_before_rst", 32'(rvalid), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rvalid_in_rst", 32'(rvalid), 32'd0);
    chk("arready_in_rst", 32'(arready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    axi_read("rd_en_post_rst", 8'h04, 32'h0, 2'b00);
    axi_read("rd_mode_post_rst", 8'h0C, 32'h0, 2'b00);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
